// File: rtl/exhaustive_gate_checker_pkg.sv
// Shared types for the exhaustive gate checker: reference modes and FSM states.
package exhaustive_gate_checker_pkg;

    // Reference function applied as a reduction over the swept vector.
    typedef enum logic [1:0] {
        ModeAnd  = 2'd0,
        ModeOr   = 2'd1,
        ModeXor  = 2'd2,
        ModeNand = 2'd3
    } gc_mode_e;

    // Sweep controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } gc_state_e;

endpackage

// File: rtl/exhaustive_gate_checker_ref_model.sv
// Pure combinational reference: expected DUT output for a given mode and input vector.
module exhaustive_gate_checker_ref_model
    import exhaustive_gate_checker_pkg::*;
#(
    parameter int unsigned IN_W = 2
) (
    input  gc_mode_e          mode,
    input  logic [IN_W-1:0]   vec,
    output logic              exp_bit
);

    // Reduction selected by mode.
    always_comb begin
        exp_bit = 1'b0;
        case (mode)
            ModeAnd:  exp_bit = &vec;
            ModeOr:   exp_bit = |vec;
            ModeXor:  exp_bit = ^vec;
            ModeNand: exp_bit = ~&vec;
            default:  exp_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/exhaustive_gate_checker.sv
// Exhaustive sweeper: drives every input vector onto a DUT, samples its 1-bit output after a
// settle window and compares against a reduction reference, reporting errors and first failure.
module exhaustive_gate_checker
    import exhaustive_gate_checker_pkg::*;
#(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [IN_W-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              first_fail_valid,
    output logic [IN_W-1:0]   first_fail_vec
);

    localparam int unsigned SCW = $clog2(SETTLE + 1);
    localparam logic [SCW-1:0] SettleLoad = SCW'(SETTLE - 1);

    gc_state_e        state_q, state_d;
    gc_mode_e         mode_q, mode_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [IN_W-1:0]  ffvec_q, ffvec_d;
    logic             pass_q, pass_d;
    logic             exp_bit;
    logic             mismatch;

    exhaustive_gate_checker_ref_model #(
        .IN_W (IN_W)
    ) u_ref (
        .mode    (mode_q),
        .vec     (vec_q),
        .exp_bit (exp_bit)
    );

    // Case-equality so an X/Z response is always treated as a mismatch.
    assign mismatch = (state_q == StCheck) && (dut_out !== exp_bit);

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= ModeAnd;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic for the sweep controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StWait;
            StWait:  if (settle_q == '0) state_d = StCheck;
            StCheck: state_d = (vec_q == '1) ? StDone : StWait;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: vector/settle counters, error count, first-fail capture, verdict.
    always_comb begin
        mode_d   = mode_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        pass_d   = pass_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = gc_mode_e'(mode);
                    vec_d    = '0;
                    settle_d = SettleLoad;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                    pass_d   = 1'b0;
                end
            end
            StWait: begin
                if (settle_q != '0) settle_d = settle_q - SCW'(1);
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                // Terminal test is all-ones, so the vector counter never wraps.
                if (vec_q == '1) begin
                    pass_d = (err_d == '0);
                end else begin
                    vec_d    = vec_q + IN_W'(1);
                    settle_d = SettleLoad;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; reported results come straight from registers.
    always_comb begin
        busy             = (state_q == StWait) || (state_q == StCheck);
        done             = (state_q == StDone);
        dut_in           = busy ? vec_q : '0;
        pass             = pass_q;
        err_cnt          = err_q;
        first_fail_valid = ffv_q;
        first_fail_vec   = ffvec_q;
    end

endmodule

// File: tb/tb_exhaustive_gate_checker.sv
// Directed bench for exhaustive_gate_checker using several parameterised instances.
module tb_exhaustive_gate_checker;

    logic       clk;
    logic       rst_n;
    logic [4:0] st;
    wire  [4:0] dn;
    logic [1:0] mode0;
    logic [1:0] sel0;
    int         n_pass;
    int         n_total;

    // u0: IN_W=2, SETTLE=1, selectable reference and selectable gate
    wire [1:0] din0;
    wire       busy0, pass0, ffv0;
    wire [7:0] err0;
    wire [1:0] ffvec0;
    logic      dout0;
    // u1: IN_W=3, XOR reference, stuck-at-0 DUT
    wire [2:0] din1;
    wire       busy1, pass1, ffv1;
    wire [7:0] err1;
    wire [2:0] ffvec1;
    // u2: IN_W=3, ERR_W=2, AND reference, inverted AND DUT
    wire [2:0] din2;
    wire       busy2, pass2, ffv2;
    wire [1:0] err2;
    wire [2:0] ffvec2;
    // u3/u4: AND gate with two-cycle registered delay, SETTLE=3 and SETTLE=1
    wire [1:0] din3, din4;
    wire       busy3, pass3, ffv3, busy4, pass4, ffv4;
    wire [7:0] err3, err4;
    wire [1:0] ffvec3, ffvec4;
    logic      r3a, r3b, r4a, r4b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel0)
            2'd0:    dout0 = &din0;
            2'd1:    dout0 = |din0;
            2'd2:    dout0 = ^din0;
            default: dout0 = ~&din0;
        endcase
    end

    always_ff @(posedge clk) begin
        r3a <= &din3;
        r3b <= r3a;
        r4a <= &din4;
        r4b <= r4a;
    end

    exhaustive_gate_checker #(.IN_W(2), .SETTLE(1), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .mode(mode0), .dut_in(din0), .dut_out(dout0),
        .busy(busy0), .done(dn[0]), .pass(pass0), .err_cnt(err0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

    exhaustive_gate_checker #(.IN_W(3), .SETTLE(1), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .mode(2'd2), .dut_in(din1), .dut_out(1'b0),
        .busy(busy1), .done(dn[1]), .pass(pass1), .err_cnt(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    exhaustive_gate_checker #(.IN_W(3), .SETTLE(1), .ERR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .mode(2'd0), .dut_in(din2), .dut_out(~&din2),
        .busy(busy2), .done(dn[2]), .pass(pass2), .err_cnt(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    exhaustive_gate_checker #(.IN_W(2), .SETTLE(3), .ERR_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .mode(2'd0), .dut_in(din3), .dut_out(r3b),
        .busy(busy3), .done(dn[3]), .pass(pass3), .err_cnt(err3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3));

    exhaustive_gate_checker #(.IN_W(2), .SETTLE(1), .ERR_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .mode(2'd0), .dut_in(din4), .dut_out(r4b),
        .busy(busy4), .done(dn[4]), .pass(pass4), .err_cnt(err4),
        .first_fail_valid(ffv4), .first_fail_vec(ffvec4));

    // Pulse start on one instance, return cycles from the accept edge to done (-1 on timeout).
    task automatic run(input int idx, output int cycles);
        @(negedge clk);
        st[idx] = 1'b1;
        @(posedge clk);
        #1 st[idx] = 1'b0;
        cycles = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (dn[idx]) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_total++; if (din0 !== 2'b00) $display("FAIL reset_dut_in got %0d want 0", din0); else n_pass++;
        n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy0); else n_pass++;
        n_total++; if (dn !== 5'b0) $display("FAIL reset_done got %b want 00000", dn); else n_pass++;
        n_total++; if (pass0 !== 1'b0) $display("FAIL reset_pass got %0b want 0", pass0); else n_pass++;
        n_total++; if (err0 !== 8'd0) $display("FAIL reset_err got %0d want 0", err0); else n_pass++;
        n_total++; if (ffv0 !== 1'b0) $display("FAIL reset_ffv got %0b want 0", ffv0); else n_pass++;
        n_total++; if (ffvec0 !== 2'd0) $display("FAIL reset_ffvec got %0d want 0", ffvec0); else n_pass++;
    endtask

    task automatic test_and_pass();
        int c;
        mode0 = 2'd0; sel0 = 2'd0;
        run(0, c);
        n_total++; if (c !== 9) $display("FAIL and_latency got %0d want 9", c); else n_pass++;
        n_total++; if (pass0 !== 1'b1) $display("FAIL and_pass got %0b want 1", pass0); else n_pass++;
        n_total++; if (err0 !== 8'd0) $display("FAIL and_err got %0d want 0", err0); else n_pass++;
        n_total++; if (ffv0 !== 1'b0) $display("FAIL and_ffv got %0b want 0", ffv0); else n_pass++;
        n_total++; if (busy0 !== 1'b0) $display("FAIL and_busy_at_done got %0b want 0", busy0); else n_pass++;
    endtask

    task automatic test_or_vs_and();
        int c;
        mode0 = 2'd0; sel0 = 2'd1;
        run(0, c);
        n_total++; if (err0 !== 8'd2) $display("FAIL or_err got %0d want 2", err0); else n_pass++;
        n_total++; if (ffvec0 !== 2'b01) $display("FAIL or_ffvec got %0d want 1", ffvec0); else n_pass++;
        n_total++; if (ffv0 !== 1'b1) $display("FAIL or_ffv got %0b want 1", ffv0); else n_pass++;
        n_total++; if (pass0 !== 1'b0) $display("FAIL or_pass got %0b want 0", pass0); else n_pass++;
    endtask

    task automatic test_xor_stuck();
        int c;
        run(1, c);
        n_total++; if (c !== 17) $display("FAIL xor_latency got %0d want 17", c); else n_pass++;
        n_total++; if (err1 !== 8'd4) $display("FAIL xor_err got %0d want 4", err1); else n_pass++;
        n_total++; if (ffvec1 !== 3'b001) $display("FAIL xor_ffvec got %0d want 1", ffvec1); else n_pass++;
        n_total++; if (pass1 !== 1'b0) $display("FAIL xor_pass got %0b want 0", pass1); else n_pass++;
    endtask

    task automatic test_saturation();
        int c;
        run(2, c);
        n_total++; if (err2 !== 2'd3) $display("FAIL sat_err got %0d want 3", err2); else n_pass++;
        n_total++; if (ffvec2 !== 3'b000) $display("FAIL sat_ffvec got %0d want 0", ffvec2); else n_pass++;
        n_total++; if (ffv2 !== 1'b1) $display("FAIL sat_ffv got %0b want 1", ffv2); else n_pass++;
        n_total++; if (pass2 !== 1'b0) $display("FAIL sat_pass got %0b want 0", pass2); else n_pass++;
    endtask

    task automatic test_registered_dut();
        int c;
        run(3, c);
        n_total++; if (c !== 17) $display("FAIL reg3_latency got %0d want 17", c); else n_pass++;
        n_total++; if (pass3 !== 1'b1) $display("FAIL reg3_pass got %0b want 1", pass3); else n_pass++;
        n_total++; if (err3 !== 8'd0) $display("FAIL reg3_err got %0d want 0", err3); else n_pass++;
        run(4, c);
        n_total++; if (pass4 !== 1'b0) $display("FAIL reg1_pass got %0b want 0", pass4); else n_pass++;
        // Two-cycle lag means only vector 3 sees a stale 0 where 1 is expected.
        n_total++; if (err4 !== 8'd1) $display("FAIL reg1_err got %0d want 1", err4); else n_pass++;
        n_total++; if (ffvec4 !== 2'd3) $display("FAIL reg1_ffvec got %0d want 3", ffvec4); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int c;
        mode0 = 2'd0; sel0 = 2'd0;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        c = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 3) begin st[0] = 1'b1; mode0 = 2'd2; end
            if (n == 5) begin st[0] = 1'b0; end
            if (dn[0]) begin
                c = n;
                break;
            end
        end
        mode0 = 2'd0;
        n_total++; if (c !== 9) $display("FAIL ign_latency got %0d want 9", c); else n_pass++;
        n_total++; if (pass0 !== 1'b1) $display("FAIL ign_pass got %0b want 1", pass0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c;
        mode0 = 2'd0; sel0 = 2'd1;
        run(0, c);
        // Hold start across the DONE edge (ignored) and the following IDLE edge (accepted).
        mode0 = 2'd3; sel0 = 2'd3;
        st[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 st[0] = 1'b0;
        @(negedge clk);
        n_total++; if (busy0 !== 1'b1) $display("FAIL b2b_busy got %0b want 1", busy0); else n_pass++;
        n_total++; if (err0 !== 8'd0) $display("FAIL b2b_err_clr got %0d want 0", err0); else n_pass++;
        n_total++; if (ffv0 !== 1'b0) $display("FAIL b2b_ffv_clr got %0b want 0", ffv0); else n_pass++;
        c = -1;
        for (int n = 2; n <= 200; n++) begin
            @(negedge clk);
            if (dn[0]) begin
                c = n;
                break;
            end
        end
        n_total++; if (c !== 9) $display("FAIL b2b_latency got %0d want 9", c); else n_pass++;
        n_total++; if (pass0 !== 1'b1) $display("FAIL b2b_pass got %0b want 1", pass0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int  c;
        bit  seen;
        bit  got_done;
        mode0 = 2'd0; sel0 = 2'd1;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (din0 == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL rst_reach_vec2 got %0b want 1", seen); else n_pass++;
        n_total++; if (err0 !== 8'd1) $display("FAIL rst_err_before got %0d want 1", err0); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (busy0 !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy0); else n_pass++;
        n_total++; if (din0 !== 2'd0) $display("FAIL rst_dut_in got %0d want 0", din0); else n_pass++;
        n_total++; if (err0 !== 8'd0) $display("FAIL rst_err got %0d want 0", err0); else n_pass++;
        got_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (dn[0]) got_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (dn[0]) got_done = 1'b1;
        end
        n_total++; if (got_done !== 1'b0) $display("FAIL rst_no_done got %0b want 0", got_done); else n_pass++;
        sel0 = 2'd0;
        run(0, c);
        n_total++; if (c !== 9) $display("FAIL rst_rerun_latency got %0d want 9", c); else n_pass++;
        n_total++; if (pass0 !== 1'b1) $display("FAIL rst_rerun_pass got %0b want 1", pass0); else n_pass++;
        n_total++; if (err0 !== 8'd0) $display("FAIL rst_rerun_err got %0d want 0", err0); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        st      = '0;
        mode0   = 2'd0;
        sel0    = 2'd0;
        rst_n   = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_and_pass();
        test_or_vs_and();
        test_xor_stuck();
        test_saturation();
        test_registered_dut();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
